dwt_l5_frame_buf: RTL

Ping-pong frame buffer directly downstream of the level-5 sym4 decomposition stage. It collects the level-5 approximation/detail coefficient pairs (fp32) as the decomposer produces them, groups them into fixed-length frames, and streams each completed frame to the consumer over a valid/ready interface. The decomposer cannot be back-pressured, so overflow is handled here by counted, frame-aligned dropping.

---
 rtl/dwt_l5_frame_buf.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/dwt_l5_frame_buf.sv
// Ping-pong frame buffer for level-5 sym4 coefficient pairs.
// The writer fills a bank, then flips to the other bank when that bank is free, or stalls and drops
// samples when it is not. The reader streams full banks oldest-first through a two-stage read/output pipeline.
module dwt_l5_frame_buf #(
  parameter int unsigned FRAME_LEN = 64
) (
  input  logic        clk_78_125,
  input  logic        rstn,
  input  logic        din_valid,
  input  logic [31:0] a5_in,
  input  logic [31:0] d5_in,
  input  logic        dout_ready,
  input  logic        clr_ovf,
  output logic        dout_valid,
  output logic [63:0] dout_data,
  output logic        dout_sof,
  output logic        dout_eof,
  output logic [7:0]  dout_frame_id,
  output logic        overflow,
  output logic [15:0] drop_cnt
);
  localparam int unsigned AW  = $clog2(FRAME_LEN);
  localparam int unsigned DW  = 64;
  localparam int unsigned IDW = 8;
  localparam int unsigned CW  = 16;
  localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {B_FREE, B_FILLING, B_FULL} bank_st_e;
  typedef enum logic {W_FILL, W_STALL} wr_st_e;
  typedef enum logic {R_IDLE, R_STREAM} rd_st_e;

  logic [DW-1:0]  mem_q [2*FRAME_LEN];
  bank_st_e       bank_st_q [2];
  bank_st_e       bank_st_d [2];
  logic [IDW-1:0] bank_id_q [2];
  logic [IDW-1:0] bank_id_d [2];

  wr_st_e         wr_st_q, wr_st_d;
  logic           wbank_q, wbank_d;
  logic [AW-1:0]  widx_q, widx_d;
  logic [IDW-1:0] wr_fid_q, wr_fid_d;
  logic           wr_en_c, drop_c, obank_c, other_free_c;

  rd_st_e         rd_st_q, rd_st_d;
  logic           rbank_q, rbank_d;
  logic [AW-1:0]  raddr_q, raddr_d;
  logic           rd_issue_c, rd_bank_c, rd_sof_c, rd_eof_c, rd_free_c;
  logic [AW-1:0]  rd_addr_c;
  logic [IDW-1:0] rd_fid_c, id_diff_c;
  logic           out_ready_c, rd_adv_c;

  logic           rd_valid_q, rd_sof_q, rd_eof_q;
  logic [DW-1:0]  rd_data_q;
  logic [IDW-1:0] rd_fid_q;

  logic           dout_valid_q, dout_sof_q, dout_eof_q, overflow_q;
  logic [DW-1:0]  dout_data_q;
  logic [IDW-1:0] dout_fid_q;
  logic [CW-1:0]  drop_cnt_q;

  assign out_ready_c = !dout_valid_q || dout_ready;
  assign rd_adv_c    = !rd_valid_q || out_ready_c;
  assign id_diff_c   = bank_id_q[0] - bank_id_q[1];

  // Reader: choose the oldest full bank, then issue one read per pipeline slot; free the bank once its last word is read out
  always_comb begin
    rd_st_d    = rd_st_q;
    rbank_d    = rbank_q;
    raddr_d    = raddr_q;
    rd_issue_c = 1'b0;
    rd_bank_c  = rbank_q;
    rd_addr_c  = raddr_q;
    rd_sof_c   = 1'b0;
    rd_eof_c   = 1'b0;
    rd_free_c  = 1'b0;
    unique case (rd_st_q)
      R_IDLE: begin
        if (rd_adv_c && (bank_st_q[0] == B_FULL || bank_st_q[1] == B_FULL)) begin
          if (bank_st_q[0] == B_FULL && bank_st_q[1] == B_FULL) rd_bank_c = !id_diff_c[IDW-1];
          else                                                   rd_bank_c = (bank_st_q[1] == B_FULL);
          rd_issue_c = 1'b1;
          rd_addr_c  = '0;
          rd_sof_c   = 1'b1;
          rbank_d    = rd_bank_c;
          raddr_d    = AW'(1);
          rd_st_d    = R_STREAM;
        end
      end
      R_STREAM: begin
        if (rd_adv_c) begin
          rd_issue_c = 1'b1;
          rd_eof_c   = (raddr_q == LAST_IDX);
          raddr_d    = raddr_q + AW'(1);
          if (rd_eof_c) begin
            rd_free_c = 1'b1;
            rd_st_d   = R_IDLE;
          end
        end
      end
      default: rd_st_d = R_IDLE;
    endcase
  end

  assign rd_fid_c = bank_id_q[rd_bank_c];

  // Writer: fill the current bank, then flip to the other bank or stall; also owns the bank-state bookkeeping
  always_comb begin
    wr_st_d      = wr_st_q;
    wbank_d      = wbank_q;
    widx_d       = widx_q;
    wr_fid_d     = wr_fid_q;
    wr_en_c      = 1'b0;
    drop_c       = 1'b0;
    bank_st_d    = bank_st_q;
    bank_id_d    = bank_id_q;
    obank_c      = ~wbank_q;
    other_free_c = (bank_st_q[obank_c] == B_FREE) || (rd_free_c && (rbank_q == obank_c));
    if (rd_free_c) bank_st_d[rbank_q] = B_FREE;
    unique case (wr_st_q)
      W_FILL: begin
        if (din_valid) begin
          wr_en_c = 1'b1;
          widx_d  = widx_q + AW'(1);
          if (widx_q == LAST_IDX) begin
            bank_st_d[wbank_q] = B_FULL;
            bank_id_d[wbank_q] = wr_fid_q;
            wr_fid_d           = wr_fid_q + IDW'(1);
            if (other_free_c) wbank_d = obank_c;
            else              wr_st_d = W_STALL;
          end else begin
            bank_st_d[wbank_q] = B_FILLING;
          end
        end
      end
      W_STALL: begin
        drop_c = din_valid;
        if (other_free_c) begin
          wr_st_d = W_FILL;
          wbank_d = obank_c;
          widx_d  = '0;
        end
      end
      default: wr_st_d = W_FILL;
    endcase
  end

  // Coefficient storage; no reset, contents are only read from full banks
  always_ff @(posedge clk_78_125) begin
    if (wr_en_c) mem_q[{wbank_q, widx_q}] <= {a5_in, d5_in};
  end

  // FSM and bank-state registers
  always_ff @(posedge clk_78_125 or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) begin
        bank_st_q[i] <= B_FREE;
        bank_id_q[i] <= '0;
      end
      wr_st_q  <= W_FILL;
      wbank_q  <= 1'b0;
      widx_q   <= '0;
      wr_fid_q <= '0;
      rd_st_q  <= R_IDLE;
      rbank_q  <= 1'b0;
      raddr_q  <= '0;
    end else begin
      bank_st_q <= bank_st_d;
      bank_id_q <= bank_id_d;
      wr_st_q   <= wr_st_d;
      wbank_q   <= wbank_d;
      widx_q    <= widx_d;
      wr_fid_q  <= wr_fid_d;
      rd_st_q   <= rd_st_d;
      rbank_q   <= rbank_d;
      raddr_q   <= raddr_d;
    end
  end

  // Read stage then output register; together they form a skid pair sustaining one word per cycle
  always_ff @(posedge clk_78_125 or negedge rstn) begin
    if (!rstn) begin
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      rd_sof_q     <= 1'b0;
      rd_eof_q     <= 1'b0;
      rd_fid_q     <= '0;
      dout_valid_q <= 1'b0;
      dout_data_q  <= '0;
      dout_sof_q   <= 1'b0;
      dout_eof_q   <= 1'b0;
      dout_fid_q   <= '0;
    end else begin
      if (rd_adv_c) begin
        rd_valid_q <= rd_issue_c;
        if (rd_issue_c) begin
          rd_data_q <= mem_q[{rd_bank_c, rd_addr_c}];
          rd_sof_q  <= rd_sof_c;
          rd_eof_q  <= rd_eof_c;
          rd_fid_q  <= rd_fid_c;
        end
      end
      if (out_ready_c) begin
        dout_valid_q <= rd_valid_q;
        if (rd_valid_q) begin
          dout_data_q <= rd_data_q;
          dout_sof_q  <= rd_sof_q;
          dout_eof_q  <= rd_eof_q;
          dout_fid_q  <= rd_fid_q;
        end
      end
    end
  end

  // Sticky overflow and saturating drop counter; a clear beats a same-cycle drop
  always_ff @(posedge clk_78_125 or negedge rstn) begin
    if (!rstn) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (clr_ovf) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop_c) begin
      overflow_q <= 1'b1;
      if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + CW'(1);
    end
  end

  assign dout_valid    = dout_valid_q;
  assign dout_data     = dout_data_q;
  assign dout_sof      = dout_sof_q;
  assign dout_eof      = dout_eof_q;
  assign dout_frame_id = dout_fid_q;
  assign overflow      = overflow_q;
  assign drop_cnt      = drop_cnt_q;

endmodule
